// File: rtl/gf_product_deskew_pkg.sv
// Shared constants for the GF(2^M) product output collector.
package gf_product_deskew_pkg;

    localparam int GF_M         = 8;
    localparam int GF_OUT_DEPTH = 4;
    localparam int GF_CNT_W     = 16;

    // Occupancy needs one extra bit so that "full" and "empty" are distinct.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gf_deskew_lane.sv
// N-stage single-bit delay line; one per product lane plus one for the start marker.
module gf_deskew_lane #(
    parameter int N = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int k = 1; k < N; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    assign q = sr[N-1];

endmodule

// File: rtl/gf_product_deskew.sv
// Removes the per-lane skew of the systolic multiplier output and queues aligned words.
module gf_product_deskew
    import gf_product_deskew_pkg::*;
#(
    parameter int M     = GF_M,
    parameter int DEPTH = GF_OUT_DEPTH,
    parameter int CNT_W = GF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_v,
    input  logic [M-1:0]     in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_data,
    output logic             overflow,
    output logic [CNT_W-1:0] out_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = occ_width(DEPTH);

    logic [M-1:0] word;
    logic         word_v;

    // Lane i arrives i cycles late, so it needs i fewer stages than lane 0.
    for (genvar i = 0; i < M; i++) begin : g_lane
        gf_deskew_lane #(.N(M - i)) u_lane (
            .clk (clk),
            .rst (rst),
            .d   (in_c[i]),
            .q   (word[i])
        );
    end

    gf_deskew_lane #(.N(M)) u_valid (
        .clk (clk),
        .rst (rst),
        .d   (in_v),
        .q   (word_v)
    );

    logic [M-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic          full;
    logic          pop;
    logic          push;

    assign full = (occ == OW'(DEPTH));
    assign pop  = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push = word_v && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            overflow  <= 1'b0;
            out_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                out_count <= out_count + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
            if (word_v && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_valid = (occ != '0);
    assign out_data  = mem[rd_ptr];

endmodule

// File: tb/tb_gf_product_deskew.sv
// Directed bench for gf_product_deskew with a queue-based reference model.
module tb_gf_product_deskew;

    localparam int M     = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             in_v;
    logic [M-1:0]     in_c;
    logic             out_valid;
    logic             out_ready;
    logic [M-1:0]     out_data;
    logic             overflow;
    logic [CNT_W-1:0] out_count;

    gf_product_deskew #(.M(M), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_v      (in_v),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents, words in flight with their push edge, sticky flag, pop count.
    logic [M-1:0] mq [$];
    int           pend_t [$];
    logic [M-1:0] pend_w [$];
    logic         hist_v [M];
    logic [M-1:0] hist_w [M];
    int           e;
    logic         m_ovf;
    int           m_cnt;
    logic         fresh;
    logic [M-1:0] got [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0)
            chk("out_data", 32'(out_data), 32'(mq[0]));
        else if (fresh)
            chk("out_data_reset", 32'(out_data), 32'd0);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("out_count", 32'(out_count), 32'(m_cnt) & 32'hFFFF);
    endtask

    task automatic model_clear();
        mq.delete();
        pend_t.delete();
        pend_w.delete();
        for (int k = 0; k < M; k++) begin
            hist_v[k] = 1'b0;
            hist_w[k] = '0;
        end
        m_ovf = 1'b0;
        m_cnt = 0;
        fresh = 1'b1;
    endtask

    // One clock: drive skewed lanes from the launch history, advance the model, compare.
    task automatic cycle(input logic launch, input logic [M-1:0] w, input logic rdy);
        for (int k = M - 1; k > 0; k--) begin
            hist_v[k] = hist_v[k-1];
            hist_w[k] = hist_w[k-1];
        end
        hist_v[0] = launch;
        hist_w[0] = w;
        in_v      = launch;
        out_ready = rdy;
        for (int i = 0; i < M; i++)
            in_c[i] = hist_v[i] ? hist_w[i][i] : 1'($urandom_range(0, 1));
        if (launch) begin
            pend_t.push_back(e + M);
            pend_w.push_back(w);
        end
        @(posedge clk);
        if (mq.size() > 0 && rdy) begin
            void'(mq.pop_front());
            m_cnt++;
        end
        if (pend_t.size() > 0 && pend_t[0] == e) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(pend_w[0]);
                fresh = 1'b0;
            end else begin
                m_ovf = 1'b1;
            end
            void'(pend_t.pop_front());
            void'(pend_w.pop_front());
        end
        e++;
        #1 compare();
    endtask

    task automatic do_reset(input int n);
        in_v = 1'b0;
        rst  = 1'b0;
        #1;
        model_clear();
        compare();
        repeat (n) begin
            @(posedge clk);
            #1 compare();
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain(input int n);
        got.delete();
        repeat (n) begin
            if (out_valid) got.push_back(out_data);
            cycle(1'b0, '0, 1'b1);
        end
    endtask

    logic [M-1:0] b2b [4] = '{8'h01, 8'h80, 8'hFF, 8'h3C};
    logic [M-1:0] bp  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [M-1:0] ov  [5] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E};

    initial begin
        rst = 1'b0; in_v = 1'b0; in_c = '0; out_ready = 1'b0; e = 0;
        model_clear();
        #2;
        do_reset(3);

        // idle after reset
        repeat (10) cycle(1'b0, '0, 1'b1);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_count", 32'(out_count), 32'd0);

        // single word: valid exactly after the 8th edge following the marker
        cycle(1'b1, 8'hA5, 1'b1);
        for (int j = 1; j <= 12; j++) begin
            cycle(1'b0, '0, 1'b1);
            chk("single_valid", 32'(out_valid), 32'(j == 8));
            if (j == 8) chk("single_data", 32'(out_data), 32'hA5);
            if (j == 9) chk("single_count", 32'(out_count), 32'd1);
        end

        // back-to-back markers
        for (int k = 0; k < 4; k++) cycle(1'b1, b2b[k], 1'b1);
        drain(12);
        chk("b2b_n", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            chk("b2b_0", 32'(got[0]), 32'h01);
            chk("b2b_1", 32'(got[1]), 32'h80);
            chk("b2b_2", 32'(got[2]), 32'hFF);
            chk("b2b_3", 32'(got[3]), 32'h3C);
        end
        chk("b2b_count", 32'(out_count), 32'd5);

        // backpressure with exactly DEPTH words
        for (int k = 0; k < 4; k++) cycle(1'b1, bp[k], 1'b0);
        repeat (12) cycle(1'b0, '0, 1'b0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head", 32'(out_data), 32'h11);
        drain(6);
        chk("bp_n", 32'(got.size()), 32'd4);
        if (got.size() == 4) chk("bp_last", 32'(got[3]), 32'h44);
        chk("bp_ovf", 32'(overflow), 32'd0);
        chk("bp_count", 32'(out_count), 32'd9);

        // overflow: fifth word dropped
        for (int k = 0; k < 5; k++) cycle(1'b1, ov[k], 1'b0);
        repeat (12) cycle(1'b0, '0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        drain(8);
        chk("ovf_n", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            chk("ovf_0", 32'(got[0]), 32'h5A);
            chk("ovf_3", 32'(got[3]), 32'h8D);
        end
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(out_count), 32'd13);

        // reset with 3 words queued and 2 still in the deskew chain
        cycle(1'b1, 8'hC1, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0);
        repeat (6) cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 8'hC4, 1'b0);
        cycle(1'b1, 8'hC5, 1'b0);
        chk("mid_valid", 32'(out_valid), 32'd1);
        do_reset(2);
        repeat (12) cycle(1'b0, '0, 1'b1);
        chk("mid_after_valid", 32'(out_valid), 32'd0);
        chk("mid_after_ovf", 32'(overflow), 32'd0);
        chk("mid_after_count", 32'(out_count), 32'd0);

        // full FIFO with simultaneous push and pop
        for (int k = 0; k < 5; k++) cycle(1'b1, 8'(8'hE0 + k), 1'b0);
        repeat (7) cycle(1'b0, '0, 1'b0);
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_head", 32'(out_data), 32'hE0);
        cycle(1'b0, '0, 1'b1);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        chk("full_pp_head", 32'(out_data), 32'hE1);
        drain(8);
        chk("full_pp_n", 32'(got.size()), 32'd4);
        if (got.size() == 4) chk("full_pp_last", 32'(got[3]), 32'hE4);
        chk("full_pp_count", 32'(out_count), 32'd5);
        chk("full_pp_ovf_end", 32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
